barcodescanner_nios_leds: RTL



---
 rtl/barcodescanner_nios_leds_pkg.sv | 15 +
 rtl/barcodescanner_nios_leds_blinker.sv | 63 ++++++
 rtl/barcodescanner_nios_leds.sv | 119 +++++++++++
 3 files changed

// File: rtl/barcodescanner_nios_leds_pkg.sv
// Shared constants for the LED output PIO: s1 word addresses and the default blink prescaler.
package barcodescanner_nios_leds_pkg;

  typedef logic [2:0] addr_t;

  localparam addr_t ADDR_DATA       = 3'd0;
  localparam addr_t ADDR_BLINK_MASK = 3'd1;
  localparam addr_t ADDR_PERIOD     = 3'd2;
  localparam addr_t ADDR_OUTSET     = 3'd4;
  localparam addr_t ADDR_OUTCLEAR   = 3'd5;

  // 1 kHz blink tick from a 50 MHz clock.
  localparam int CLK_DIV_DEFAULT = 50000;

endpackage

// File: rtl/barcodescanner_nios_leds_blinker.sv
// Blink timebase: prescaler -> tick, tick counter -> phase flop toggling every PERIOD ticks.
module barcodescanner_nios_leds_blinker
  import barcodescanner_nios_leds_pkg::*;
#(
  parameter int CLK_DIV      = CLK_DIV_DEFAULT,
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    period_wr,
  output logic                    phase
);

  localparam int                PRESC_W   = $clog2(CLK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);

  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic [PERIOD_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
  logic                    phase_q, phase_d;
  logic                    tick;

  assign tick = (presc_q == PRESC_MAX);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    presc_d    = presc_q;
    tick_cnt_d = tick_cnt_q;
    phase_d    = phase_q;
    if (period_wr || (period == '0)) begin
      // A PERIOD write restarts the timebase and wins over a tick landing on the same edge.
      presc_d    = '0;
      tick_cnt_d = '0;
      phase_d    = 1'b0;
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (tick_cnt_q == period - 1'b1) begin
          tick_cnt_d = '0;
          phase_d    = ~phase_q;
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= '0;
      tick_cnt_q <= '0;
      phase_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so all flops sample pre-edge values together.
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      phase_q    <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/barcodescanner_nios_leds.sv
// Avalon-MM LED output PIO with atomic set/clear; the hardware blink engine is built only
// when BARCODESCANNER_NIOS_LEDS_BLINK_EN is defined.
module barcodescanner_nios_leds
  import barcodescanner_nios_leds_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
  parameter int                    CLK_DIV      = CLK_DIV_DEFAULT,
  parameter int                    PERIOD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic                  wr;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] out_reg_q, out_reg_d;
  logic [DATA_WIDTH-1:0] out_port_q, out_port_d;
  logic [DATA_WIDTH-1:0] blink_bits;
  logic [31:0]           readdata_q, readdata_d;

  assign wr = chipselect & ~write_n;
  assign wd = writedata[DATA_WIDTH-1:0];

`ifdef BARCODESCANNER_NIOS_LEDS_BLINK_EN
  logic [DATA_WIDTH-1:0]   mask_q, mask_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic                    period_wr;
  logic                    phase;
  logic                    unused_wd;

  assign period_wr = wr && (address == ADDR_PERIOD);
  assign unused_wd = &{1'b0, writedata};

  always_comb begin
    mask_d   = mask_q;
    period_d = period_q;
    if (wr && (address == ADDR_BLINK_MASK)) mask_d = wd;
    if (period_wr) period_d = writedata[PERIOD_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q   <= '0;
      period_q <= '0;
    end else begin
      mask_q   <= mask_d;
      period_q <= period_d;
    end
  end

  barcodescanner_nios_leds_blinker #(
    .CLK_DIV      (CLK_DIV),
    .PERIOD_WIDTH (PERIOD_WIDTH)
  ) u_blinker (
    .clk       (clk),
    .reset_n   (reset_n),
    .period    (period_q),
    .period_wr (period_wr),
    .phase     (phase)
  );

  assign blink_bits = mask_q & {DATA_WIDTH{phase}};
`else
  logic unused_cfg;

  assign blink_bits = '0;
  assign unused_cfg = &{1'b0, writedata, (CLK_DIV > 1), (PERIOD_WIDTH > 0)};
`endif

  always_comb begin
    out_reg_d = out_reg_q;
    if (wr) begin
      case (address)
        ADDR_DATA:     out_reg_d = wd;
        ADDR_OUTSET:   out_reg_d = out_reg_q | wd;
        ADDR_OUTCLEAR: out_reg_d = out_reg_q & ~wd;
        default:       out_reg_d = out_reg_q;
      endcase
    end
  end

  // DATA reads return the software-owned register, never the blinked pin value.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:       readdata_d = 32'(out_reg_q);
`ifdef BARCODESCANNER_NIOS_LEDS_BLINK_EN
      ADDR_BLINK_MASK: readdata_d = 32'(mask_q);
      ADDR_PERIOD:     readdata_d = 32'(period_q);
`endif
      default:         readdata_d = '0;
    endcase
  end

  assign out_port_d = out_reg_q ^ blink_bits;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg_q  <= RESET_VALUE;
      out_port_q <= RESET_VALUE;
      readdata_q <= '0;
    end else begin
      out_reg_q  <= out_reg_d;
      out_port_q <= out_port_d;
      readdata_q <= readdata_d;
    end
  end

  assign out_port = out_port_q;
  assign readdata = readdata_q;

endmodule
